// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule helper functions and the round-control state type.
package sha256_pkg;

    localparam int ROUNDS = 64;
    localparam int CNT_W  = 5;
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(ROUNDS / 2 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] H_INIT =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// One message-schedule word: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], mod 2^32.
module sha256_sched_word
    import sha256_pkg::*;
(
    input  logic [31:0] w_t,
    input  logic [31:0] w_t1,
    input  logic [31:0] w_t9,
    input  logic [31:0] w_t14,
    output logic [31:0] w_t16
);

    assign w_t16 = sig1(w_t14) + w_t9 + sig0(w_t1) + w_t;

endmodule

// File: rtl/sha256_sched2.sv
// Two-words-per-cycle SHA-256 message schedule and round control feeding the compression stage.
module sha256_sched2
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block_i,
    output logic         busy,
    output logic [31:0]  w_o1,
    output logic [31:0]  k_o1,
    output logic [31:0]  w_o2,
    output logic [31:0]  k_o2,
    output logic         sel,
    output logic         rdy_o,
    output logic [4:0]   round_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       win_q [16];
    logic [31:0]       win_d [16];
    logic [31:0]       new14, new15;

    // Both new words read only the pre-shift window, so the two adders run in parallel.
    sha256_sched_word u_word14 (
        .w_t   (win_q[0]),
        .w_t1  (win_q[1]),
        .w_t9  (win_q[9]),
        .w_t14 (win_q[14]),
        .w_t16 (new14)
    );

    sha256_sched_word u_word15 (
        .w_t   (win_q[1]),
        .w_t1  (win_q[2]),
        .w_t9  (win_q[10]),
        .w_t14 (win_q[15]),
        .w_t16 (new15)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end
        busy    = 1'b0;
        sel     = 1'b0;
        rdy_o   = 1'b0;
        w_o1    = '0;
        w_o2    = '0;
        k_o1    = '0;
        k_o2    = '0;
        round_o = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = block_i[511 - 32*i -: 32];
                    end
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                sel     = 1'b1;
                w_o1    = win_q[0];
                w_o2    = win_q[1];
                k_o1    = K[{cnt_q, 1'b0}];
                k_o2    = K[{cnt_q, 1'b1}];
                round_o = cnt_q;
                for (int i = 0; i < 14; i++) begin
                    win_d[i] = win_q[i+2];
                end
                win_d[14] = new14;
                win_d[15] = new15;
                // Counter wraps to zero on the last issue cycle, ready for the next block.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ISSUE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                rdy_o   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_sched2.sv
// Scoreboard bench for sha256_sched2: expected W/K streams from an independent schedule model.
module tb_sha256_sched2;
    import sha256_pkg::*;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] block_i;
    logic         busy;
    logic [31:0]  w_o1, k_o1, w_o2, k_o2;
    logic         sel;
    logic         rdy_o;
    logic [4:0]   round_o;

    sha256_sched2 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .block_i (block_i),
        .busy    (busy),
        .w_o1    (w_o1),
        .k_o1    (k_o1),
        .w_o2    (w_o2),
        .k_o2    (k_o2),
        .sel     (sel),
        .rdy_o   (rdy_o),
        .round_o (round_o)
    );

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ONES_BLK = {512{1'b1}};
    localparam logic [255:0] ABC_DIG  =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    typedef struct {
        logic        isDone;
        logic [31:0] w1, w2, k1, k2;
        logic [4:0]  rnd;
        logic        hand;
        logic        chk;
        logic [255:0] dig;
    } exp_t;

    exp_t         sb[$];
    exp_t         monE;
    int           errors = 0;
    int           checks = 0;
    logic         monEn = 1'b0;
    logic [255:0] hState = H_INIT;
    int           runLen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] doRound(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] addH(input logic [255:0] s);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) begin
            r[255 - 32*j -: 32] = H_INIT[255 - 32*j -: 32] + s[255 - 32*j -: 32];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Expected stream uses the textbook recurrence over a full 64-word array.
    task automatic pushExpected(input logic [511:0] blk, input logic hand, input logic chk, input logic [255:0] dig);
        logic [31:0] w [64];
        exp_t e;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = blk[511 - 32*t -: 32];
            else        w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
        end
        for (int i = 0; i < 32; i++) begin
            e.isDone = 1'b0;
            e.w1 = w[2*i];   e.w2 = w[2*i+1];
            e.k1 = KT[2*i];  e.k2 = KT[2*i+1];
            e.rnd = 5'(i);   e.hand = hand;
            e.chk = 1'b0;    e.dig = '0;
            sb.push_back(e);
        end
        e.isDone = 1'b1;
        e.w1 = '0; e.w2 = '0; e.k1 = '0; e.k2 = '0; e.rnd = '0;
        e.hand = 1'b0; e.chk = chk; e.dig = dig;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [511:0] blk, input logic hand, input logic chk, input logic [255:0] dig);
        pushExpected(blk, hand, chk, dig);
        block_i = blk;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("overlap_busy", {sel & rdy_o, busy}, {1'b0, sel | rdy_o});
            if (sel || rdy_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow: got sel=%0b rdy_o=%0b required no output", sel, rdy_o);
                end else begin
                    monE = sb.pop_front();
                    checkOutput("stream", {sel, rdy_o, w_o1, w_o2, k_o1, k_o2, round_o},
                                {!monE.isDone, monE.isDone, monE.w1, monE.w2, monE.k1, monE.k2, monE.rnd});
                    if (sel) begin
                        if (monE.hand && monE.rnd == 5'd0)
                            checkOutput("abc_round0", {w_o1, w_o2, k_o1, k_o2},
                                        {32'h61626380, 32'h00000000, 32'h428a2f98, 32'h71374491});
                        if (monE.hand && monE.rnd == 5'd8)
                            checkOutput("abc_round8", {w_o1, w_o2}, {32'h61626380, 32'h000F0000});
                        if (monE.hand && monE.rnd == 5'd31)
                            checkOutput("abc_round31", {k_o1, k_o2}, {32'hbef9a3f7, 32'hc67178f2});
                        hState = doRound(doRound(hState, k_o1, w_o1), k_o2, w_o2);
                        runLen++;
                    end else begin
                        checkOutput("run_length", runLen, 32);
                        if (monE.chk) checkOutput("digest", addH(hState), monE.dig);
                        hState = H_INIT;
                        runLen = 0;
                    end
                end
            end else begin
                checkOutput("idle_zero", {w_o1, w_o2, k_o1, k_o2, round_o}, '0);
                hState = H_INIT;
                runLen = 0;
            end
        end
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        block_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", {busy, sel, rdy_o, w_o1, w_o2, k_o1, k_o2, round_o}, '0);
        rst   = 1'b1;
        monEn = 1'b1;
        tick(1);

        // Plain "abc" run with latency checks around the ready pulse.
        applyStimulus(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
        tick(31);
        checkOutput("rdy_not_early", {sel, rdy_o}, 2'b10);
        tick(1);
        checkOutput("rdy_latency", {sel, rdy_o}, 2'b01);
        tick(1);
        checkOutput("after_rdy_idle", {busy, sel, rdy_o}, 3'b000);
        tick(2);

        // A second start mid-run with a different block must be ignored.
        applyStimulus(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
        tick(10);
        start   = 1'b1;
        block_i = ONES_BLK;
        tick(1);
        start   = 1'b0;
        tick(26);
        checkOutput("ignored_start_drained", sb.size(), 0);

        // Reset during RUN cycle 15 abandons the block without a ready pulse.
        applyStimulus(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
        tick(14);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        sb.delete();
        checkOutput("reset_midrun", {busy, sel, rdy_o, w_o1, w_o2, k_o1, k_o2, round_o}, '0);
        tick(40);
        applyStimulus(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
        tick(36);
        checkOutput("after_reset_drained", sb.size(), 0);

        // Start held high: abc then all-ones, one idle cycle between them.
        pushExpected(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
        pushExpected(ONES_BLK, 1'b0, 1'b0, '0);
        block_i = ABC_BLK;
        start   = 1'b1;
        tick(1);
        block_i = ONES_BLK;
        tick(32);
        checkOutput("b2b_rdy", {sel, rdy_o, busy}, 3'b011);
        tick(1);
        checkOutput("b2b_idle", {busy, sel, rdy_o}, 3'b000);
        tick(1);
        start = 1'b0;
        checkOutput("b2b_second_run", {sel, round_o}, {1'b1, 5'd0});
        tick(40);

        checkOutput("sb_final_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
